// File: rtl/gpio_pkg.sv
// Shared address-map helpers and change-detect encodings for the GPIO controller.
package gpio_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic int gpo_idx(input int num_in, input int j);
    return num_in + j;
  endfunction

  function automatic int stat_idx(input int num_in, input int num_out);
    return num_in + num_out;
  endfunction

  function automatic int mask_idx(input int num_in, input int num_out);
    return num_in + num_out + 1;
  endfunction

endpackage

// File: rtl/gpio_in_chan.sv
// One GPIO input channel: 2-flop synchroniser, previous-value register and
// change-detect flag.
module gpio_in_chan
  import gpio_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pin_i,
  output logic [DATA_W-1:0] sync_o,
  output logic              detect_o
);

  logic [DATA_W-1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    detect_o = 1'b0;
    if (EDGE_MODE == EDGE_FALL)     detect_o = |(~sync2_q & prev_q);
    else if (EDGE_MODE == EDGE_ANY) detect_o = |(sync2_q ^ prev_q);
    else                            detect_o = |(sync2_q & ~prev_q);
  end

  assign sync_o = sync2_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: synchronised inputs, output registers,
// write-1-to-clear change status, interrupt mask and registered irq.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_IN    = 2,
  parameter int NUM_OUT   = 2,
  parameter int ADDR_W    = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         A,
  input  logic                      WE,
  input  logic [DATA_W-1:0]         WD,
  output logic [DATA_W-1:0]         RD,
  input  logic [NUM_IN*DATA_W-1:0]  gpi,
  output logic [NUM_OUT*DATA_W-1:0] gpo,
  output logic                      irq
);

  localparam int STAT_IDX = stat_idx(NUM_IN, NUM_OUT);
  localparam int MASK_IDX = mask_idx(NUM_IN, NUM_OUT);

  logic [DATA_W-1:0] gpi_sync [NUM_IN];
  logic [NUM_IN-1:0] detect;
  logic [DATA_W-1:0] gpo_q [NUM_OUT];
  logic [DATA_W-1:0] gpo_d [NUM_OUT];
  logic [NUM_IN-1:0] stat_q, stat_d, mask_q, mask_d;
  logic              irq_q;
  logic [1:0]        warm_q;
  logic              armed;
  int                a_idx;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    gpio_in_chan #(.DATA_W(DATA_W), .EDGE_MODE(EDGE_MODE)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .pin_i    (gpi[k*DATA_W +: DATA_W]),
      .sync_o   (gpi_sync[k]),
      .detect_o (detect[k])
    );
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    assign gpo[j*DATA_W +: DATA_W] = gpo_q[j];
  end

  assign a_idx = int'(A);
  // STAT may only set once prev holds a real pin sample; before that the
  // synchroniser is still refilling from its zeroed reset state.
  assign armed = (warm_q == 2'd3);

  always_comb begin
    stat_d = (detect & {NUM_IN{armed}}) |
             (stat_q & ~((WE && a_idx == STAT_IDX) ? WD[NUM_IN-1:0] : '0));
    mask_d = (WE && a_idx == MASK_IDX) ? WD[NUM_IN-1:0] : mask_q;
    for (int j = 0; j < NUM_OUT; j++) begin
      gpo_d[j] = (WE && a_idx == gpo_idx(NUM_IN, j)) ? WD : gpo_q[j];
    end
  end

  always_comb begin
    RD = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (a_idx == k) RD = gpi_sync[k];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (a_idx == gpo_idx(NUM_IN, j)) RD = gpo_q[j];
    end
    if (a_idx == STAT_IDX) RD[NUM_IN-1:0] = stat_q;
    if (a_idx == MASK_IDX) RD[NUM_IN-1:0] = mask_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_OUT; j++) gpo_q[j] <= '0;
      stat_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
      warm_q <= 2'd0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) gpo_q[j] <= gpo_d[j];
      stat_q <= stat_d;
      mask_q <= mask_d;
      irq_q  <= |(stat_q & mask_q);
      if (!armed) warm_q <= warm_q + 2'd1;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Randomised bench for gpio_ctrl; one instance per edge mode against a
// pin-history reference model.
module tb_gpio_ctrl;

  localparam int DW = 32;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [AW-1:0]       A;
  logic                WE;
  logic [DW-1:0]       WD;
  logic [NI*DW-1:0]    gpi;
  logic [DW-1:0]       rd  [3];
  logic [NO*DW-1:0]    gpo [3];
  logic                irq [3];

  gpio_ctrl #(.DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .ADDR_W(AW), .EDGE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .A(A), .WE(WE), .WD(WD), .RD(rd[0]),
    .gpi(gpi), .gpo(gpo[0]), .irq(irq[0]));
  gpio_ctrl #(.DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .ADDR_W(AW), .EDGE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .A(A), .WE(WE), .WD(WD), .RD(rd[1]),
    .gpi(gpi), .gpo(gpo[1]), .irq(irq[1]));
  gpio_ctrl #(.DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .ADDR_W(AW), .EDGE_MODE(2)) dut2 (
    .clk(clk), .rst(rst), .A(A), .WE(WE), .WD(WD), .RD(rd[2]),
    .gpi(gpi), .gpo(gpo[2]), .irq(irq[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: GPI reads the pin value sampled two edges ago, STAT
  // compares the samples taken two and three edges ago.
  logic [31:0] m_gpo [2];
  logic [1:0]  m_mask;
  logic [1:0]  m_stat [3];
  logic        m_irq [3];
  logic [63:0] h1, h2, h3;
  int          ecnt;

  function automatic logic fires(input int mode, input logic [31:0] cur, input logic [31:0] prv);
    case (mode)
      0:       return |(cur & ~prv);
      1:       return |(~cur & prv);
      default: return |(cur ^ prv);
    endcase
  endfunction

  task automatic model_reset();
    m_gpo[0] = '0; m_gpo[1] = '0; m_mask = '0;
    for (int m = 0; m < 3; m++) begin m_stat[m] = '0; m_irq[m] = 1'b0; end
    h1 = '0; h2 = '0; h3 = '0; ecnt = 0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic we, input logic [31:0] wd,
                            input logic [63:0] pins);
    logic [1:0] clr, det;
    clr = (we && a == 4'd4) ? wd[1:0] : 2'b00;
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 2; k++)
        det[k] = (ecnt >= 3) && fires(m, h2[k*32 +: 32], h3[k*32 +: 32]);
      m_irq[m]  = |(m_stat[m] & m_mask);
      m_stat[m] = det | (m_stat[m] & ~clr);
    end
    if (we && a == 4'd5) m_mask   = wd[1:0];
    if (we && a == 4'd2) m_gpo[0] = wd;
    if (we && a == 4'd3) m_gpo[1] = wd;
    h3 = h2; h2 = h1; h1 = pins;
    ecnt++;
  endtask

  function automatic logic [31:0] model_rd(input int m, input logic [3:0] a);
    case (a)
      4'd0:    return h2[31:0];
      4'd1:    return h2[63:32];
      4'd2:    return m_gpo[0];
      4'd3:    return m_gpo[1];
      4'd4:    return {30'b0, m_stat[m]};
      4'd5:    return {30'b0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("gpo0_m%0d", m), 64'(gpo[m][31:0]), 64'(m_gpo[0]));
      chk($sformatf("gpo1_m%0d", m), 64'(gpo[m][63:32]), 64'(m_gpo[1]));
      chk($sformatf("irq_m%0d", m), 64'(irq[m]), 64'(m_irq[m]));
      chk($sformatf("rd_a%0d_m%0d", A, m), 64'(rd[m]), 64'(model_rd(m, A)));
    end
  endtask

  task automatic step(input logic [3:0] a, input logic we, input logic [31:0] wd,
                      input logic [63:0] pins);
    A = a; WE = we; WD = wd; gpi = pins;
    @(posedge clk);
    model_edge(a, we, wd, pins);
    #1;
    check_all();
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_gpo_m0", gpo[0], 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [63:0] p;
  logic [3:0]  ra;

  initial begin
    rst = 1'b1; A = '0; WE = 1'b0; WD = '0; gpi = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
    repeat (4) step(4'd4, 1'b0, 32'h0, 64'h0);

    // Reset with pins held high: no status after release
    repeat (4) step(4'd0, 1'b0, 32'h0, '1);
    pulse_rst();
    for (int i = 0; i < 4; i++) begin
      step(4'd4, 1'b0, 32'h0, '1);
      chk("stat_after_rst_m0", 64'(rd[0]), 64'h0);
      chk("stat_after_rst_m2", 64'(rd[2]), 64'h0);
    end

    // GPO write / readback
    step(4'd2, 1'b1, 32'hDEADBEEF, '1);
    chk("gpo_wr", 64'(gpo[0][31:0]), 64'hDEADBEEF);
    step(4'd2, 1'b0, 32'h0, '1);
    chk("gpo_rd", 64'(rd[0]), 64'hDEADBEEF);
    step(4'd3, 1'b0, 32'h0, '1);
    chk("gpo1_rd", 64'(rd[0]), 64'h0);

    // Synchroniser latency on ch0
    repeat (4) step(4'd0, 1'b0, 32'h0, 64'h0);
    step(4'd4, 1'b1, 32'h3, 64'h0);
    repeat (3) step(4'd0, 1'b0, 32'h0, 64'h0);
    p = 64'h1;
    step(4'd0, 1'b0, 32'h0, p);
    chk("gpi_lat1", 64'(rd[0]), 64'h0);
    step(4'd0, 1'b0, 32'h0, p);
    chk("gpi_lat2", 64'(rd[0]), 64'h1);
    step(4'd4, 1'b0, 32'h0, p);
    chk("stat_set", 64'(rd[0]), 64'h1);
    chk("irq_unmasked", 64'(irq[0]), 64'h0);

    // Interrupt path
    step(4'd5, 1'b1, 32'h1, p);
    step(4'd4, 1'b1, 32'h3, p);
    repeat (3) step(4'd4, 1'b0, 32'h0, 64'h0);
    step(4'd4, 1'b1, 32'h3, 64'h0);
    repeat (3) step(4'd4, 1'b0, 32'h0, p);
    chk("irq_lag", 64'(irq[0]), 64'h0);
    step(4'd4, 1'b0, 32'h0, p);
    chk("irq_set", 64'(irq[0]), 64'h1);
    step(4'd4, 1'b1, 32'h1, p);
    chk("stat_w1c", 64'(rd[0]), 64'h0);
    step(4'd4, 1'b0, 32'h0, p);
    chk("irq_clr", 64'(irq[0]), 64'h0);

    // Set beats simultaneous write-1-to-clear
    p = 64'h0000_0001_0000_0001;
    step(4'd4, 1'b0, 32'h0, p);
    step(4'd4, 1'b0, 32'h0, p);
    step(4'd4, 1'b1, 32'h2, p);
    chk("set_wins", 64'(rd[0][1]), 64'h1);

    // Unmapped and read-only writes
    step(4'd7, 1'b1, 32'hFFFF, p);
    chk("unmapped_rd", 64'(rd[0]), 64'h0);
    step(4'd0, 1'b1, 32'hFFFF, p);
    chk("gpi_ro", 64'(rd[0]), 64'h1);

    // Falling-edge build sees only the fall
    step(4'd4, 1'b1, 32'h3, p);
    repeat (3) step(4'd4, 1'b0, 32'h0, 64'h0);
    chk("fall_m1", 64'(rd[1]), 64'h3);
    chk("fall_m0", 64'(rd[0]), 64'h0);

    // Randomised traffic
    p = 64'h0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        pulse_rst();
      end else begin
        case ($urandom_range(3))
          0: ;
          1: p[$urandom_range(63)] = ~p[$urandom_range(63)];
          2: p = {$urandom, $urandom};
          default: p[$urandom_range(3)] = ~p[$urandom_range(3)];
        endcase
        ra = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(5));
        step(ra, ($urandom_range(2) == 0), $urandom, p);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
